// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file port arbiter: controller state and requester identity.
package regfile_arb_pkg;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } requester_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Zero-clear sweep sequencer: walks every register index once, one per cycle,
// and flags the final index so the arbiter can return to normal service.
module regfile_clear_seq #(
    parameter int A = 4
) (
    input  logic         Clk,
    input  logic         ResetN,
    input  logic         start,
    output logic         busy,
    output logic [A-1:0] index,
    output logic         done
);

    // One extra bit keeps the final index distinct from the post-wrap value.
    localparam logic [A:0] LAST = (A+1)'((1 << A) - 1);

    logic [A:0] idx_q;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            busy  <= 1'b0;
            idx_q <= '0;
        end else if (!busy) begin
            if (start) begin
                busy  <= 1'b1;
                idx_q <= '0;
            end
        end else begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == LAST) busy <= 1'b0;
        end
    end

    assign done  = busy && (idx_q == LAST);
    assign index = idx_q[A-1:0];

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one register-file address port between Core and Dbg with Core priority,
// a starvation guard for Dbg, and an on-command zero-clear sweep.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int W      = 8,
    parameter int A      = 4,
    parameter int STARVE = 4
) (
    input  logic         Clk,
    input  logic         ResetN,
    input  logic         ClearReq,
    output logic         ClearBusy,
    input  logic         CoreReqValid,
    output logic         CoreReqReady,
    input  logic         CoreReqWrite,
    input  logic         CoreReqR0,
    input  logic [A-1:0] CoreReqAddr,
    input  logic [W-1:0] CoreReqData,
    output logic         CoreRspValid,
    output logic [W-1:0] CoreRspData,
    input  logic         DbgReqValid,
    output logic         DbgReqReady,
    input  logic         DbgReqWrite,
    input  logic         DbgReqR0,
    input  logic [A-1:0] DbgReqAddr,
    input  logic [W-1:0] DbgReqData,
    output logic         DbgRspValid,
    output logic [W-1:0] DbgRspData,
    output logic         RfWriteEn,
    output logic         RfWriteR0,
    output logic [A-1:0] RfReg,
    output logic [W-1:0] RfDataIn,
    input  logic [W-1:0] RfDataOut
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE);

    arb_state_t   state_q, state_d;
    requester_t   sel;
    logic [3:0]   starve_q;
    logic         core_win, dbg_win, gnt, contested;
    logic         sel_write, sel_r0;
    logic [A-1:0] sel_addr;
    logic [W-1:0] sel_data;
    logic         clr_start, clr_done;
    logic [A-1:0] clr_index;

    regfile_clear_seq #(.A(A)) u_clear (
        .Clk    (Clk),
        .ResetN (ResetN),
        .start  (clr_start),
        .busy   (ClearBusy),
        .index  (clr_index),
        .done   (clr_done)
    );

    assign contested = CoreReqValid && DbgReqValid;
    assign gnt       = core_win || dbg_win;
    assign sel       = dbg_win ? REQ_DBG : REQ_CORE;
    assign sel_write = (sel == REQ_DBG) ? DbgReqWrite : CoreReqWrite;
    assign sel_r0    = (sel == REQ_DBG) ? DbgReqR0    : CoreReqR0;
    assign sel_addr  = (sel == REQ_DBG) ? DbgReqAddr  : CoreReqAddr;
    assign sel_data  = (sel == REQ_DBG) ? DbgReqData  : CoreReqData;

    assign CoreReqReady = core_win;
    assign DbgReqReady  = dbg_win;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) state_q <= SERVE;
        else         state_q <= state_d;
    end

    // Grants are qualified by ResetN so every output reads 0 while reset is held.
    always_comb begin
        state_d   = state_q;
        core_win  = 1'b0;
        dbg_win   = 1'b0;
        clr_start = 1'b0;
        RfWriteEn = 1'b0;
        RfWriteR0 = 1'b0;
        RfReg     = '0;
        RfDataIn  = '0;
        unique case (state_q)
            SERVE: begin
                if (ResetN) begin
                    if (CoreReqValid && (!DbgReqValid || starve_q != STARVE_LIM))
                        core_win = 1'b1;
                    else if (DbgReqValid)
                        dbg_win = 1'b1;
                    if (ClearReq) begin
                        state_d   = CLEAR;
                        clr_start = 1'b1;
                    end
                end
                if (gnt) begin
                    if (sel_write && sel_r0) begin
                        RfWriteR0 = 1'b1;
                        RfDataIn  = sel_data;
                    end else if (sel_write) begin
                        RfWriteEn = 1'b1;
                        RfReg     = sel_addr;
                        RfDataIn  = sel_data;
                    end else begin
                        RfReg = sel_addr;
                    end
                end
            end
            CLEAR: begin
                RfWriteEn = 1'b1;
                RfReg     = clr_index;
                if (clr_done) state_d = SERVE;
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            starve_q <= '0;
        end else if (dbg_win) begin
            starve_q <= '0;
        end else if (core_win && contested) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    // Read data is captured from the combinational register-file output in the grant cycle.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            CoreRspValid <= 1'b0;
            CoreRspData  <= '0;
            DbgRspValid  <= 1'b0;
            DbgRspData   <= '0;
        end else begin
            CoreRspValid <= core_win && !CoreReqWrite;
            DbgRspValid  <= dbg_win && !DbgReqWrite;
            if (core_win && !CoreReqWrite) CoreRspData <= RfDataOut;
            if (dbg_win && !DbgReqWrite)   DbgRspData  <= RfDataOut;
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: vector table plus sequences, with a behavioural
// register file and a read-response scoreboard.
module tb_regfile_port_arbiter;
    localparam int W = 8, A = 4, STARVE = 4, N = 1 << A;
    localparam logic T = 1'b1, F = 1'b0;

    typedef struct {
        logic cv, cw, cr0; logic [A-1:0] ca; logic [W-1:0] cd;
        logic dv, dw, dr0; logic [A-1:0] da; logic [W-1:0] dd;
        logic clr;
        logic ecr, edr, ewe, ewr0, ebusy; logic [A-1:0] ereg; logic [W-1:0] edin;
    } vec_t;

    typedef struct {
        logic dbg;
        logic [W-1:0] data;
    } rsp_t;

    logic Clk = 1'b0, ResetN = 1'b0, ClearReq = 1'b0, ClearBusy;
    logic CoreReqValid = 1'b0, CoreReqReady, CoreReqWrite = 1'b0, CoreReqR0 = 1'b0;
    logic [A-1:0] CoreReqAddr = '0;
    logic [W-1:0] CoreReqData = '0;
    logic CoreRspValid;
    logic [W-1:0] CoreRspData;
    logic DbgReqValid = 1'b0, DbgReqReady, DbgReqWrite = 1'b0, DbgReqR0 = 1'b0;
    logic [A-1:0] DbgReqAddr = '0;
    logic [W-1:0] DbgReqData = '0;
    logic DbgRspValid;
    logic [W-1:0] DbgRspData;
    logic RfWriteEn, RfWriteR0;
    logic [A-1:0] RfReg;
    logic [W-1:0] RfDataIn, RfDataOut;

    int tests = 0, fails = 0;
    logic rf_init = 1'b1;
    logic [W-1:0] rf [N];
    logic [W-1:0] shadow [N];
    rsp_t sb [$];
    vec_t vecs [13];

    always #5 Clk = ~Clk;

    regfile_port_arbiter #(.W(W), .A(A), .STARVE(STARVE)) dut (
        .Clk(Clk), .ResetN(ResetN), .ClearReq(ClearReq), .ClearBusy(ClearBusy),
        .CoreReqValid(CoreReqValid), .CoreReqReady(CoreReqReady), .CoreReqWrite(CoreReqWrite),
        .CoreReqR0(CoreReqR0), .CoreReqAddr(CoreReqAddr), .CoreReqData(CoreReqData),
        .CoreRspValid(CoreRspValid), .CoreRspData(CoreRspData),
        .DbgReqValid(DbgReqValid), .DbgReqReady(DbgReqReady), .DbgReqWrite(DbgReqWrite),
        .DbgReqR0(DbgReqR0), .DbgReqAddr(DbgReqAddr), .DbgReqData(DbgReqData),
        .DbgRspValid(DbgRspValid), .DbgRspData(DbgRspData),
        .RfWriteEn(RfWriteEn), .RfWriteR0(RfWriteR0), .RfReg(RfReg),
        .RfDataIn(RfDataIn), .RfDataOut(RfDataOut)
    );

    // Behavioural register file: combinational read, writes land at the clock edge.
    always @(posedge Clk) begin
        if (rf_init) begin
            for (int i = 0; i < N; i++) rf[i] <= '0;
        end else begin
            if (RfWriteEn) rf[RfReg] <= RfDataIn;
            if (RfWriteR0) rf[0] <= RfDataIn;
        end
    end
    assign RfDataOut = rf[RfReg];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic vec_t nv();
        vec_t v;
        v = '{F,F,F,4'd0,8'h00, F,F,F,4'd0,8'h00, F, F,F,F,F,F,4'd0,8'h00};
        return v;
    endfunction

    // Drive one cycle, check combinational outputs and due responses, then advance.
    task automatic step(input vec_t v);
        rsp_t e;
        CoreReqValid = v.cv; CoreReqWrite = v.cw; CoreReqR0 = v.cr0;
        CoreReqAddr = v.ca; CoreReqData = v.cd;
        DbgReqValid = v.dv; DbgReqWrite = v.dw; DbgReqR0 = v.dr0;
        DbgReqAddr = v.da; DbgReqData = v.dd;
        ClearReq = v.clr;
        @(negedge Clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("core_rsp_valid", 32'(CoreRspValid), 32'(!e.dbg));
            chk("dbg_rsp_valid", 32'(DbgRspValid), 32'(e.dbg));
            if (e.dbg) chk("dbg_rsp_data", 32'(DbgRspData), 32'(e.data));
            else       chk("core_rsp_data", 32'(CoreRspData), 32'(e.data));
        end else begin
            chk("core_rsp_idle", 32'(CoreRspValid), 32'(0));
            chk("dbg_rsp_idle", 32'(DbgRspValid), 32'(0));
        end
        chk("core_ready", 32'(CoreReqReady), 32'(v.ecr));
        chk("dbg_ready", 32'(DbgReqReady), 32'(v.edr));
        chk("rf_we", 32'(RfWriteEn), 32'(v.ewe));
        chk("rf_wr0", 32'(RfWriteR0), 32'(v.ewr0));
        chk("rf_reg", 32'(RfReg), 32'(v.ereg));
        chk("rf_din", 32'(RfDataIn), 32'(v.edin));
        chk("clear_busy", 32'(ClearBusy), 32'(v.ebusy));
        if (v.ecr && v.cv && !v.cw) sb.push_back('{1'b0, shadow[v.ca]});
        if (v.edr && v.dv && !v.dw) sb.push_back('{1'b1, shadow[v.da]});
        if (v.ewe)  shadow[v.ereg] = v.edin;
        if (v.ewr0) shadow[0] = v.edin;
        @(posedge Clk);
        #1;
    endtask

    task automatic preload_ff();
        vec_t v;
        for (int i = 0; i < N; i++) begin
            v = nv();
            v.cv = T; v.cw = T; v.ca = A'(i); v.cd = 8'hFF;
            v.ecr = T; v.ewe = T; v.ereg = A'(i); v.edin = 8'hFF;
            step(v);
        end
    endtask

    task automatic clear_cycle(input int idx);
        vec_t v;
        v = nv();
        v.cv = T; v.dv = T; v.ca = 4'd1; v.da = 4'd2; v.clr = T;
        v.ewe = T; v.ereg = A'(idx); v.ebusy = T;
        step(v);
    endtask

    task automatic dbg_read_all();
        vec_t v;
        for (int i = 0; i < N; i++) begin
            v = nv();
            v.dv = T; v.da = A'(i); v.edr = T; v.ereg = A'(i);
            step(v);
        end
        step(nv());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic [9:0] dwin;
        for (int i = 0; i < N; i++) shadow[i] = '0;

        vecs[0]  = '{T,F,F,4'd1,8'h00, T,F,F,4'd2,8'h00, F, T,F,F,F,F,4'd1,8'h00};
        vecs[1]  = '{T,T,F,4'd3,8'hA5, F,F,F,4'd0,8'h00, F, T,F,T,F,F,4'd3,8'hA5};
        vecs[2]  = '{T,F,F,4'd3,8'h00, F,F,F,4'd0,8'h00, F, T,F,F,F,F,4'd3,8'h00};
        vecs[3]  = '{F,F,F,4'd0,8'h00, F,F,F,4'd0,8'h00, F, F,F,F,F,F,4'd0,8'h00};
        vecs[4]  = '{F,F,F,4'd0,8'h00, T,T,T,4'd7,8'h3C, F, F,T,F,T,F,4'd0,8'h3C};
        vecs[5]  = '{F,F,F,4'd0,8'h00, T,F,F,4'd0,8'h00, F, F,T,F,F,F,4'd0,8'h00};
        vecs[6]  = '{F,F,F,4'd0,8'h00, T,F,F,4'd7,8'h00, F, F,T,F,F,F,4'd7,8'h00};
        vecs[7]  = '{T,F,T,4'd5,8'h00, F,F,F,4'd0,8'h00, F, T,F,F,F,F,4'd5,8'h00};
        vecs[8]  = '{T,T,F,4'd7,8'h11, T,T,F,4'd8,8'h22, F, T,F,T,F,F,4'd7,8'h11};
        vecs[9]  = '{F,F,F,4'd0,8'h00, T,T,F,4'd8,8'h22, F, F,T,T,F,F,4'd8,8'h22};
        vecs[10] = '{T,F,F,4'd8,8'h00, T,F,F,4'd7,8'h00, F, T,F,F,F,F,4'd8,8'h00};
        vecs[11] = '{F,F,F,4'd0,8'h00, T,F,F,4'd7,8'h00, F, F,T,F,F,F,4'd7,8'h00};
        vecs[12] = '{F,F,F,4'd0,8'h00, F,F,F,4'd0,8'h00, F, F,F,F,F,F,4'd0,8'h00};

        // Reset held with both requesters asking to write: everything stays quiet.
        CoreReqValid = T; CoreReqWrite = T; CoreReqAddr = 4'd3; CoreReqData = 8'h55;
        DbgReqValid = T; DbgReqWrite = T; DbgReqAddr = 4'd4; DbgReqData = 8'h66;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_core_ready", 32'(CoreReqReady), 32'(0));
        chk("rst_dbg_ready", 32'(DbgReqReady), 32'(0));
        chk("rst_rf_we", 32'(RfWriteEn), 32'(0));
        chk("rst_rf_wr0", 32'(RfWriteR0), 32'(0));
        chk("rst_rf_reg", 32'(RfReg), 32'(0));
        chk("rst_rf_din", 32'(RfDataIn), 32'(0));
        chk("rst_busy", 32'(ClearBusy), 32'(0));
        chk("rst_core_rspv", 32'(CoreRspValid), 32'(0));
        chk("rst_dbg_rspv", 32'(DbgRspValid), 32'(0));
        chk("rst_core_rspd", 32'(CoreRspData), 32'(0));
        chk("rst_dbg_rspd", 32'(DbgRspData), 32'(0));
        @(posedge Clk);
        #1;
        rf_init = 1'b0;
        ResetN = 1'b1;

        for (int i = 0; i < 13; i++) step(vecs[i]);

        // Continuous contention: Dbg forced through on every fifth cycle.
        dwin = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            v = nv();
            v.cv = T; v.ca = 4'd1; v.dv = T; v.da = 4'd2;
            v.ecr = !dwin[i]; v.edr = dwin[i]; v.ereg = dwin[i] ? 4'd2 : 4'd1;
            step(v);
        end
        step(nv());

        // Full sweep; the read issued alongside ClearReq answers in the first sweep cycle.
        preload_ff();
        v = nv();
        v.cv = T; v.ca = 4'd2; v.clr = T; v.ecr = T; v.ereg = 4'd2;
        step(v);
        for (int i = 0; i < N; i++) clear_cycle(i);
        dbg_read_all();

        // Reset landing mid-sweep at index 5 leaves the upper registers untouched.
        preload_ff();
        v = nv();
        v.clr = T;
        step(v);
        for (int i = 0; i < 5; i++) clear_cycle(i);
        ResetN = 1'b0;
        #1;
        chk("abort_busy", 32'(ClearBusy), 32'(0));
        chk("abort_rf_we", 32'(RfWriteEn), 32'(0));
        chk("abort_rf_reg", 32'(RfReg), 32'(0));
        chk("abort_core_ready", 32'(CoreReqReady), 32'(0));
        chk("abort_dbg_ready", 32'(DbgReqReady), 32'(0));
        @(posedge Clk);
        #1;
        ResetN = 1'b1;
        sb.delete();
        dbg_read_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
